// File: rtl/media_ctrl.sv
// Averaging sequencer: runs K=2**LOG_K ADC conversions over soc/eoc, averages them and
// presents the mean over dav_/rfd. Define MEDIA_CTRL_MINMAX_EN to also report batch min/max.
module media_ctrl #(
  parameter int N     = 8,
  parameter int LOG_K = 2
) (
  input  logic         clock,
  input  logic         reset_,
  output logic         soc,
  input  logic         eoc,
  input  logic [N-1:0] x,
  output logic         dav_,
  input  logic         rfd,
  output logic [N-1:0] media
`ifdef MEDIA_CTRL_MINMAX_EN
  ,
  output logic [N-1:0] min_v,
  output logic [N-1:0] max_v
`endif
);

  localparam int AW = N + LOG_K;
  localparam logic [LOG_K-1:0] CNT_LAST = {LOG_K{1'b1}};

  typedef enum logic [2:0] {
    S_START,
    S_SOC,
    S_WAIT,
    S_OUT,
    S_ACK,
    S_REL
  } state_t;

  state_t           state_reg, state_next;
  logic             soc_reg, soc_next;
  logic             dav_reg, dav_next;
  logic [N-1:0]     media_reg, media_next;
  logic [AW-1:0]    acc_reg, acc_next;
  logic [LOG_K-1:0] cnt_reg, cnt_next;
  logic [AW-1:0]    sum;

  // Accumulator width holds K full-scale samples, so the sum never wraps.
  assign sum = acc_reg + AW'(x);

`ifdef MEDIA_CTRL_MINMAX_EN
  logic [N-1:0] mn_reg, mn_next;
  logic [N-1:0] mx_reg, mx_next;
  logic [N-1:0] min_reg, min_next;
  logic [N-1:0] max_reg, max_next;

  assign min_v = min_reg;
  assign max_v = max_reg;
`endif

  assign soc   = soc_reg;
  assign dav_  = dav_reg;
  assign media = media_reg;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_reg <= S_START;
      soc_reg   <= 1'b0;
      dav_reg   <= 1'b1;
      media_reg <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
`ifdef MEDIA_CTRL_MINMAX_EN
      mn_reg    <= '1;
      mx_reg    <= '0;
      min_reg   <= '0;
      max_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      soc_reg   <= soc_next;
      dav_reg   <= dav_next;
      media_reg <= media_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
`ifdef MEDIA_CTRL_MINMAX_EN
      mn_reg    <= mn_next;
      mx_reg    <= mx_next;
      min_reg   <= min_next;
      max_reg   <= max_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    soc_next   = soc_reg;
    dav_next   = dav_reg;
    media_next = media_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
`ifdef MEDIA_CTRL_MINMAX_EN
    mn_next    = mn_reg;
    mx_next    = mx_reg;
    min_next   = min_reg;
    max_next   = max_reg;
`endif
    case (state_reg)
      S_START: begin
        soc_next   = 1'b1;
        acc_next   = '0;
        cnt_next   = '0;
`ifdef MEDIA_CTRL_MINMAX_EN
        mn_next    = '1;
        mx_next    = '0;
`endif
        state_next = S_SOC;
      end
      // eoc already high here is stale; only its fall acknowledges this request.
      S_SOC: begin
        if (!eoc) begin
          soc_next   = 1'b0;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eoc) begin
          acc_next = sum;
          cnt_next = cnt_reg + LOG_K'(1);
`ifdef MEDIA_CTRL_MINMAX_EN
          if (x < mn_reg) mn_next = x;
          if (mx_reg < x) mx_next = x;
`endif
          if (cnt_reg == CNT_LAST) begin
            state_next = S_OUT;
          end else begin
            soc_next   = 1'b1;
            state_next = S_SOC;
          end
        end
      end
      S_OUT: begin
        media_next = acc_reg[AW-1:LOG_K];
`ifdef MEDIA_CTRL_MINMAX_EN
        min_next   = mn_reg;
        max_next   = mx_reg;
`endif
        dav_next   = 1'b0;
        state_next = S_ACK;
      end
      S_ACK: begin
        if (!rfd) begin
          dav_next   = 1'b1;
          state_next = S_REL;
        end
      end
      S_REL: begin
        if (rfd) state_next = S_START;
      end
      default: state_next = S_START;
    endcase
  end

endmodule
